// File: rtl/pipes_pkg.sv
// Shared pipeline types: per-stage payload structs, their widths, and the stage handshake bundle.
// Also holds small elaboration-time helpers used by pipe_elastic_stage.
package pipes_pkg;

   typedef logic u1;

   typedef struct packed {
      u1 valid;
      u1 ready;
   } pipe_hs_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_data_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      u1           mem_rd;
      u1           mem_wr;
      u1           reg_wr;
   } decode_data_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [4:0]  rd;
      u1           mem_rd;
      u1           mem_wr;
      u1           reg_wr;
   } execute_data_t;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd;
      u1           reg_wr;
   } memory_data_t;

   typedef struct packed {
      logic [31:0] wb_data;
      logic [4:0]  rd;
      u1           reg_wr;
   } writeback_data_t;

   localparam int FETCH_W     = $bits(fetch_data_t);
   localparam int DECODE_W    = $bits(decode_data_t);
   localparam int EXECUTE_W   = $bits(execute_data_t);
   localparam int MEMORY_W    = $bits(memory_data_t);
   localparam int WRITEBACK_W = $bits(writeback_data_t);

   // A single-entry buffer still needs a 1-bit pointer to keep the declarations legal.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module pipe_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] value
);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (inc && (value != '1)) begin
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic valid/ready FIFO stage between pipeline stages, DEPTH entries deep, with synchronous
// flush and a saturating count of downstream back-pressure cycles.
module pipe_elastic_stage
   import pipes_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2,
   parameter int STAT_W = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [STAT_W-1:0]          stall_cycles
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = ptr_width(DEPTH);

   if (DEPTH < 1 || DATA_W < 1 || STAT_W < 1) begin : g_bad_params
      $error("pipe_elastic_stage: DEPTH, DATA_W and STAT_W must all be >= 1");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count_next;
   logic              push;
   logic              pop;

   // Explicit wrap so non-power-of-two depths never index past the last entry.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   if (DEPTH == 1) begin : g_single
      // A full register can still accept when the head leaves in the same cycle.
      assign in_ready = (count == '0) | out_ready;
   end else begin : g_skid
      assign in_ready = (count < CNT_W'(DEPTH));
   end

   assign out_valid  = (count != '0);
   assign out_data   = mem[rd_ptr];
   assign push       = in_valid & in_ready & ~flush;
   assign pop        = out_valid & out_ready;
   assign count_next = count + CNT_W'(push) - CNT_W'(pop);

   // NOTE: storage is cleared by reset here so out_data reads 0 while empty; drop the loop if that is not needed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         count <= count_next;
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
      end
   end

   pipe_sat_counter #(
      .W (STAT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid & ~out_ready),
      .clear (1'b0),
      .value (stall_cycles)
   );

   a_count_bound : assert property (@(posedge clk) disable iff (reset)
      count <= CNT_W'(DEPTH));
   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed bench for pipe_elastic_stage: DEPTH=2 (STAT_W=4), DEPTH=1 and DEPTH=3 instances
// share clock and reset; each is driven through its own handshake signals.
module tb_pipe_elastic_stage;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   // Instance a: DEPTH=2, STAT_W=4
   logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0] a_in_data, a_out_data;
   logic [1:0] a_count;
   logic [3:0] a_stall;

   // Instance b: DEPTH=1
   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0]  b_in_data, b_out_data;
   logic [0:0]  b_count;
   logic [31:0] b_stall;

   // Instance c: DEPTH=3
   logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
   logic [7:0]  c_in_data, c_out_data;
   logic [1:0]  c_count;
   logic [31:0] c_stall;

   pipe_elastic_stage #(.DATA_W(8), .DEPTH(2), .STAT_W(4)) u_a (
      .clk(clk), .reset(reset), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .count(a_count), .stall_cycles(a_stall)
   );

   pipe_elastic_stage #(.DATA_W(8), .DEPTH(1), .STAT_W(32)) u_b (
      .clk(clk), .reset(reset), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .count(b_count), .stall_cycles(b_stall)
   );

   pipe_elastic_stage #(.DATA_W(8), .DEPTH(3), .STAT_W(32)) u_c (
      .clk(clk), .reset(reset), .flush(c_flush),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .count(c_count), .stall_cycles(c_stall)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] pat;
      int          mcount, exp_out, next_in, maxc;
      logic        do_push, do_pop;

      reset = 1'b1;
      {a_flush, a_in_valid, a_out_ready, a_in_data} = '0;
      {b_flush, b_in_valid, b_out_ready, b_in_data} = '0;
      {c_flush, c_in_valid, c_out_ready, c_in_data} = '0;
      #12;

      // Reset state
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_data",  a_out_data,  0);
      check("rst_in_ready",  a_in_ready,  1);
      check("rst_count",     a_count,     0);
      check("rst_stall",     a_stall,     0);
      check("rst_b_in_ready", b_in_ready, 1);
      reset = 1'b0;

      // DEPTH=2 fill with back-pressure, then drain in order
      a_in_valid = 1'b1; a_in_data = 8'h11;
      tick();
      check("a_fill1_count", a_count, 1);
      check("a_fill1_data",  a_out_data, 8'h11);
      a_in_data = 8'h22;
      tick();
      check("a_full_count",    a_count, 2);
      check("a_full_in_ready", a_in_ready, 0);
      check("a_full_data",     a_out_data, 8'h11);
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      tick();
      check("a_drain1_data",  a_out_data, 8'h22);
      check("a_drain1_count", a_count, 1);
      tick();
      check("a_drain2_valid", a_out_valid, 0);
      check("a_drain2_count", a_count, 0);

      // Flush while full with an incoming transfer: 0x33 must never appear
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h44;
      tick();
      a_in_data = 8'h55;
      tick();
      check("a_pre_flush_count", a_count, 2);
      a_flush = 1'b1; a_in_data = 8'h33;
      tick();
      check("a_flush_count", a_count, 0);
      check("a_flush_valid", a_out_valid, 0);
      a_flush = 1'b0; a_in_valid = 1'b0;
      tick();
      check("a_post_flush_valid", a_out_valid, 0);
      a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h66;
      tick();
      check("a_after_flush_data", a_out_data, 8'h66);
      check("a_after_flush_count", a_count, 1);
      a_in_valid = 1'b0;
      tick();
      check("a_after_flush_empty", a_out_valid, 0);
      check("a_stall_no_clear_on_flush", a_stall, 3);

      // Reset between edges with two entries held
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h77;
      tick();
      a_in_data = 8'h88;
      tick();
      a_in_valid = 1'b0;
      check("a_held_count", a_count, 2);
      #2 reset = 1'b1;
      #1;
      check("a_midrst_valid",    a_out_valid, 0);
      check("a_midrst_count",    a_count, 0);
      check("a_midrst_in_ready", a_in_ready, 1);
      check("a_midrst_data",     a_out_data, 0);
      check("a_midrst_stall",    a_stall, 0);
      reset = 1'b0;
      a_in_valid = 1'b1; a_in_data = 8'h99;
      tick();
      check("a_post_rst_data",  a_out_data, 8'h99);
      check("a_post_rst_count", a_count, 1);

      // Stall counter saturation at 15 (STAT_W=4)
      a_in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("a_stall_10", a_stall, 10);
      for (int i = 0; i < 10; i++) tick();
      check("a_stall_sat", a_stall, 15);
      a_out_ready = 1'b1;
      tick();
      check("a_stall_hold", a_stall, 15);
      check("a_stall_drained", a_out_valid, 0);

      // DEPTH=1 full-rate streaming
      b_out_ready = 1'b1; b_in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         b_in_data = 8'(i);
         tick();
         check("b_stream_valid", b_out_valid, 1);
         check("b_stream_data",  b_out_data, i);
         check("b_stream_in_ready", b_in_ready, 1);
      end
      b_in_valid = 1'b0;
      tick();
      check("b_stream_end", b_out_valid, 0);

      // DEPTH=1 back-pressure then pop+push swap
      b_in_valid = 1'b1; b_in_data = 8'h0a;
      tick();
      b_out_ready = 1'b0; b_in_data = 8'h0b;
      #1;
      check("b_bp_in_ready", b_in_ready, 0);
      tick();
      check("b_bp_hold", b_out_data, 8'h0a);
      b_out_ready = 1'b1;
      tick();
      check("b_swap_data",  b_out_data, 8'h0b);
      check("b_swap_count", b_count, 1);
      b_in_valid = 1'b0;
      tick();
      check("b_swap_empty", b_out_valid, 0);

      // DEPTH=3 interleaved push/pop with a fixed ready pattern
      pat     = 16'b0110_1011_1010_0000;
      mcount  = 0;
      exp_out = 0;
      next_in = 0;
      maxc    = 0;
      for (int cyc = 0; cyc < 200 && exp_out < 10; cyc++) begin
         c_in_valid  = (next_in < 10);
         c_in_data   = 8'(next_in);
         c_out_ready = pat[cyc % 16];
         #1;
         check("c_in_ready", c_in_ready, (mcount < 3) ? 1 : 0);
         do_push = c_in_valid && (mcount < 3);
         do_pop  = c_out_ready && (mcount > 0);
         if (do_pop) begin
            check("c_order", c_out_data, exp_out);
            exp_out++;
         end
         if (do_push) next_in++;
         mcount = mcount + int'(do_push) - int'(do_pop);
         tick();
         check("c_count", c_count, mcount);
         if (int'(c_count) > maxc) maxc = int'(c_count);
      end
      c_in_valid = 1'b0;
      check("c_all_out",   exp_out, 10);
      check("c_max_count", maxc, 3);
      check("c_end_empty", c_out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
